mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Arbitrates one single-port unified memory between two requesters: instruction fetch (IF stage) and data access (MEM stage loads/stores).
- Sequences each transaction through a req/gnt/rvalid handshake with variable memory latency.
- Drives stall requests that the pipeline hazard logic ORs into its stall/flush decisions.
- Data accesses win by default, so an older instruction in MEM is never blocked by a younger fetch.

Parameters:
ADDR_W, 32, address width of both requesters and of the memory port
DATA_W, 32, data width; byte enable width is DATA_W/8
STARVE_LIMIT, 4, consecutive data grants allowed while a fetch waits (used only with ARB_FAIR_EN); range 1..15

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request, level, held until if_rvalid
if_addr  in  ADDR_W  fetch address, stable while if_req
if_rdata  out  DATA_W  fetch data, valid with if_rvalid
if_rvalid  out  1  one-cycle fetch completion pulse
dm_req  in  1  data request, level, held until dm_rvalid
dm_we  in  1  1 = store, 0 = load
dm_be  in  DATA_W/8  store byte enables
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_rdata  out  DATA_W  load data, valid with dm_rvalid
dm_rvalid  out  1  one-cycle completion pulse, loads and stores
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_be  out  DATA_W/8  memory byte enables
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_gnt  in  1  memory accepted request this cycle
mem_rvalid  in  1  memory response/ack
mem_rdata  in  DATA_W  memory read data
stall_f  out  1  fetch stall request to hazard unit
stall_m  out  1  MEM-stage stall request to hazard unit
busy  out  1  FSM not in IDLE

Behaviour:
- Reset: asynchronous on rst_n low; the FSM goes to IDLE and the starve counter goes to 0.
- Reset values: mem_req, mem_we, if_rvalid, dm_rvalid = 0; mem_be, mem_addr, mem_wdata = 0; busy = 0.
- Reset mid-transaction: any outstanding response is abandoned. Memory shares rst_n.
- FSM states: IDLE, REQ_I, WAIT_I, REQ_D, WAIT_D.
- IDLE:
  - dm_req goes to REQ_D; otherwise if_req goes to REQ_I; otherwise stay in IDLE.
  - Both requests high: data wins (unless the fairness rule applies).
- REQ_x:
  - mem_req = 1; mem_addr/we/be/wdata are muxed from the owner. Fetch drives we = 0, be = all ones, wdata = 0.
  - Hold until mem_gnt = 1, then go to WAIT_x.
- WAIT_x:
  - mem_req = 0; outputs return to 0.
  - On mem_rvalid: pulse x_rvalid for exactly that cycle, pass mem_rdata through to x_rdata (combinational), then go to IDLE.
- Protocol rules:
  - Memory asserts mem_rvalid at least 1 cycle after gnt.
  - mem_rvalid in IDLE or REQ_x is ignored.
  - if_rdata and dm_rdata are 0 when their rvalid is low.
- Throughput:
  - Minimum 3 cycles per transaction: REQ with gnt, WAIT with rvalid, IDLE.
  - The IDLE bubble is mandatory because the requester's req is still high in its rvalid cycle.
- Stall outputs (combinational):
  - stall_f = if_req & ~if_rvalid
  - stall_m = dm_req & ~dm_rvalid
- busy = (state != IDLE).
- The owner is latched on leaving IDLE. The other requester's inputs never affect mem_* during a transaction.

Optional Feature:
ARB_FAIR_EN
- Defined:
  - A 4-bit starve counter increments on each REQ_D entry taken while if_req = 1.
  - The counter clears on REQ_I entry, or when if_req = 0 in IDLE.
  - In IDLE with both requests high and count >= STARVE_LIMIT, the fetch is granted instead.
- Undefined: strict data priority; no counter logic is present.

Test Plan:
- Fetch only: if_req = 1, if_addr = 0x100, gnt after 2 cycles, rvalid 1 cycle later with rdata = 0x00500093 -> mem_addr = 0x100 with we = 0; if_rvalid pulses once with if_rdata = 0x00500093; stall_f high until that pulse.
- Simultaneous: if_req and dm_req (load 0x2000) rise in the same cycle -> data served first, then after an IDLE bubble the fetch is served; stall_f stays high throughout data service.
- Store: dm_we = 1, be = 4'b0011, addr = 0x2004, wdata = 0xDEADBEEF -> mem_* carry exactly these values in REQ_D; dm_rvalid pulses on ack; dm_rdata = 0.
- Gnt stall: mem_gnt held low for 5 cycles -> mem_req and address stay stable for all 5 cycles; no rvalid pulse is produced.
- Reset mid-WAIT_D: rst_n low for 1 cycle -> all outputs 0 immediately; a later mem_rvalid is ignored; the next dm_req restarts at REQ_D.
- ARB_FAIR_EN with STARVE_LIMIT = 2: dm_req and if_req held high continuously -> grant order D, D, I, D, D, I.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between instruction fetch (IF) and data
//   access (MEM). Each transaction runs REQ (until mem_gnt) -> WAIT (until
//   mem_rvalid) -> IDLE. Data accesses win ties so the older MEM-stage
//   instruction never waits on a younger fetch.
//
//   Optional build macro ARB_FAIR_EN: a starve counter lets a waiting fetch
//   win after STARVE_LIMIT consecutive data grants. Undefined = strict data
//   priority with no counter hardware.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   if_req/if_addr           fetch request (level) and address
//   if_rdata/if_rvalid       fetch data and one-cycle completion pulse
//   dm_req/we/be/addr/wdata  data request (level), store controls
//   dm_rdata/dm_rvalid       load data and one-cycle completion pulse
//   mem_req/we/be/addr/wdata memory request side
//   mem_gnt/rvalid/rdata     memory accept, response and read data
//   stall_f, stall_m         stall requests to the hazard unit
//   busy                     FSM not in IDLE
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_rvalid,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [DATA_W/8-1:0] dm_be,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_rvalid,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall_f,
  output logic                stall_m,
  output logic                busy
);

  if ((STARVE_LIMIT == 0) || (STARVE_LIMIT > 15)) begin : g_bad_starve_limit
    $error("mem_port_arbiter: STARVE_LIMIT must be in 1..15");
  end

  typedef enum logic [2:0] {
    IDLE,
    REQ_I,
    WAIT_I,
    REQ_D,
    WAIT_D
  } state_e;

  state_e state_q, state_d;
  logic   fetch_turn;  // in IDLE, a waiting fetch beats a pending data access

`ifdef ARB_FAIR_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_q, starve_d;

  assign fetch_turn = if_req && (starve_q >= LIMIT);

  // Counts data grants taken while a fetch was waiting; any fetch grant or
  // an IDLE cycle without a fetch pending restarts the count.
  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE) begin
      if (!if_req) begin
        starve_d = '0;
      end else if (dm_req && !fetch_turn) begin
        starve_d = starve_q + 4'd1;
      end else begin
        starve_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign fetch_turn = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Ownership is carried by the state itself, so the non-owner's inputs
  // cannot reach the memory port until the transaction returns to IDLE.
  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if_rvalid = 1'b0;
    dm_rvalid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dm_req && !fetch_turn) begin
          state_d = REQ_D;
        end else if (if_req) begin
          state_d = REQ_I;
        end
      end
      REQ_I: begin
        mem_req  = 1'b1;
        mem_be   = '1;
        mem_addr = if_addr;
        if (mem_gnt) state_d = WAIT_I;
      end
      WAIT_I: begin
        if_rvalid = mem_rvalid;
        if (mem_rvalid) state_d = IDLE;
      end
      REQ_D: begin
        mem_req   = 1'b1;
        mem_we    = dm_we;
        mem_be    = dm_be;
        mem_addr  = dm_addr;
        mem_wdata = dm_wdata;
        if (mem_gnt) state_d = WAIT_D;
      end
      WAIT_D: begin
        dm_rvalid = mem_rvalid;
        if (mem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read data is a gated pass-through so idle cycles present zero.
  assign if_rdata = if_rvalid ? mem_rdata : '0;
  assign dm_rdata = dm_rvalid ? mem_rdata : '0;

  assign stall_f = if_req & ~if_rvalid;
  assign stall_m = dm_req & ~dm_rvalid;
  assign busy    = (state_q != IDLE);

endmodule
